reg_display_scanner: RTL and testbench

Downstream display stage for the CPU register file. It replaces the fixed three-register static seven-segment outputs with one time-multiplexed 8-digit hex display. A debounced push-button steps through CPU registers 0..NUM_REGS-1. The block drives a register-index select to the CPU-side read mux, snapshots the returned 32-bit value once per scan frame, and scans its 8 nibbles onto active-low anodes and segments.

---
 rtl/reg_display_scanner.sv | 137 +++++++++++++
 tb/tb_reg_display_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_display_scanner.sv
// Register-file viewer: a debounced button steps reg_sel, and the selected value is
// snapshotted once per scan frame and multiplexed onto an 8-digit hex display.
module reg_display_scanner #(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int NUM_REGS     = 26,
    parameter int BLANK_LZ     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic        sel_pulse,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [4:0]    SEL_LAST  = 5'(NUM_REGS - 1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [31:0]   snapshot_q, snapshot_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          btn_deb_q, btn_deb_d;
    logic [4:0]    reg_sel_q, reg_sel_d;
    logic          sel_pulse_q, sel_pulse_d;
    logic [7:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic [2:0]    hi_idx;
    logic [3:0]    nibble;
    logic          btn_rise;

    // Snapshot only at the frame boundary so one frame never mixes two values.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        snapshot_d  = snapshot_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 3'd1;
            if (digit_idx_q == 3'd7) snapshot_d = reg_data;
        end
    end

    always_comb begin
        hi_idx = 3'd0;
        for (int i = 1; i < 8; i++)
            if (snapshot_q[4*i +: 4] != 4'h0) hi_idx = 3'(i);
        nibble  = snapshot_q[{digit_idx_q, 2'b00} +: 4];
        an_n_d  = ~(8'd1 << digit_idx_q);
        seg_n_d = hex_glyph(nibble);
        if ((BLANK_LZ != 0) && (digit_idx_q > hi_idx)) seg_n_d = 7'h7F;
    end

    // Any return to the accepted level restarts qualification from zero.
    always_comb begin
        sync1_d   = btn_next;
        sync2_d   = sync1_q;
        deb_cnt_d = deb_cnt_q;
        btn_deb_d = btn_deb_q;
        btn_rise  = 1'b0;
        if (sync2_q == btn_deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d = '0;
            btn_deb_d = sync2_q;
            btn_rise  = sync2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_comb begin
        reg_sel_d   = reg_sel_q;
        sel_pulse_d = btn_rise;
        if (btn_rise) reg_sel_d = (reg_sel_q == SEL_LAST) ? 5'd0 : reg_sel_q + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= 3'd0;
            snapshot_q  <= 32'd0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            btn_deb_q   <= 1'b0;
            reg_sel_q   <= 5'd0;
            sel_pulse_q <= 1'b0;
            an_n_q      <= 8'hFE;
            seg_n_q     <= 7'h40;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            snapshot_q  <= snapshot_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_cnt_q   <= deb_cnt_d;
            btn_deb_q   <= btn_deb_d;
            reg_sel_q   <= reg_sel_d;
            sel_pulse_q <= sel_pulse_d;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
        end
    end

    assign reg_sel   = reg_sel_q;
    assign sel_pulse = sel_pulse_q;
    assign an_n      = an_n_q;
    assign seg_n     = seg_n_q;
endmodule

// File: tb/tb_reg_display_scanner.sv
// Scoreboard bench for reg_display_scanner: stimulus queues expected digits and
// register steps, independent monitors pop and compare when the DUT presents them.
module tb_reg_display_scanner;
    localparam int SD = 4;
    localparam int DC = 8;
    localparam int NR = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_next = 1'b0;
    logic [31:0] reg_data = 32'd0;
    logic [4:0]  reg_sel;
    logic        sel_pulse;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;

    reg_display_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC), .NUM_REGS(NR), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .reg_data(reg_data),
        .reg_sel(reg_sel), .sel_pulse(sel_pulse), .an_n(an_n), .seg_n(seg_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] sel;
        int         cyc;
    } sel_exp_t;

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_pulse = 0;
    sel_exp_t   sel_q[$];
    logic [14:0] disp_q[$];
    sel_exp_t   sexp;
    logic [14:0] dexp;
    logic [7:0] prev_an = 8'hFE;
    int         hold = 0;
    bit         prev_popped = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Register-step monitor: every sel_pulse must match a queued press.
    always @(negedge clk) begin
        if (rst_n && sel_pulse) begin
            n_pulse++;
            if (sel_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_sel_pulse: got pulse with reg_sel %0d, expected no pulse", reg_sel);
            end else begin
                sexp = sel_q.pop_front();
                check("reg_sel", 32'(reg_sel), 32'(sexp.sel));
                check("sel_cycle", cyc, sexp.cyc);
            end
        end
    end

    // Display monitor: each anode change is a new digit; compare while expectations are queued.
    always @(negedge clk) begin
        if (rst_n && (an_n !== prev_an)) begin
            if (disp_q.size() != 0) begin
                dexp = disp_q.pop_front();
                check("digit", 32'({an_n, seg_n}), 32'(dexp));
                if (prev_popped) check("digit_hold", hold, SD);
                prev_popped = 1'b1;
            end else begin
                prev_popped = 1'b0;
            end
            hold = 1;
        end else begin
            hold++;
        end
        prev_an = an_n;
    end

    // segs holds digit7..digit0 glyphs, 7 bits each; queued for the next frame.
    task automatic push_frame(input logic [55:0] segs);
        int t = 0;
        logic [7:0] a;
        @(negedge clk);
        while (an_n !== 8'h7F && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_sync: an_n %h, expected 7f within 200 cycles", an_n);
        end else begin
            @(posedge clk);
            for (int d = 0; d < 8; d++) begin
                a = ~(8'd1 << d);
                disp_q.push_back({a, segs[7*d +: 7]});
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (disp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (disp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_drain: %0d digits still pending, expected 0", disp_q.size());
            disp_q.delete();
        end
    endtask

    // Called at a negedge: hold the button long enough to qualify, then release.
    task automatic press(input logic [4:0] exp_sel);
        sel_q.push_back('{sel: exp_sel, cyc: cyc + DC + 2});
        btn_next = 1'b1;
        repeat (DC + 4) @(negedge clk);
        btn_next = 1'b0;
        repeat (DC + 4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reg_data = 32'h1234ABCD;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an_n", 32'(an_n), 32'h FE);
        check("reset_seg_n", 32'(seg_n), 32'h40);
        check("reset_reg_sel", 32'(reg_sel), 32'd0);
        check("reset_sel_pulse", 32'(sel_pulse), 32'd0);
        rst_n = 1'b1;

        // Full hex value: D,C,B,A,4,3,2,1 from digit 0 upward
        push_frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
        drain();

        // Leading-zero blanking
        reg_data = 32'h000000A0;
        push_frame({{6{7'h7F}}, 7'h08, 7'h40});
        drain();
        reg_data = 32'h00000000;
        push_frame({{7{7'h7F}}, 7'h40});
        drain();

        // Mid-frame data change must not tear the frame
        reg_data = 32'h11111111;
        push_frame({8{7'h79}});
        t = 0;
        while (an_n !== 8'hF7 && t < 100) begin
            @(negedge clk);
            t++;
        end
        reg_data = 32'h22222222;
        drain();
        push_frame({8{7'h24}});
        drain();

        // Glitchy press: 5 high, 2 low, then steady high -> single step
        @(negedge clk);
        btn_next = 1'b1;
        repeat (5) @(negedge clk);
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
        press(5'd1);

        // Remaining presses wrap 25 -> 0 on the 26th
        for (int k = 2; k <= NR; k++) press(5'(k % NR));
        check("pulse_count_26", n_pulse, 26);
        check("reg_sel_wrapped", 32'(reg_sel), 32'd0);

        press(5'd1);

        // Reset mid-debounce with the button held
        btn_next = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_an_n", 32'(an_n), 32'hFE);
        check("midrst_seg_n", 32'(seg_n), 32'h40);
        check("midrst_reg_sel", 32'(reg_sel), 32'd0);
        check("midrst_sel_pulse", 32'(sel_pulse), 32'd0);
        repeat (2) @(negedge clk);
        sel_q.push_back('{sel: 5'd1, cyc: cyc + DC + 2});
        rst_n = 1'b1;
        repeat (DC + 6) @(negedge clk);
        btn_next = 1'b0;
        repeat (DC + 6) @(negedge clk);

        check("sel_queue_empty", sel_q.size(), 0);
        check("final_reg_sel", 32'(reg_sel), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
